varint_boundary_scanner: RTL and testbench
==========================================

# varint_boundary_scanner

Streaming front-end for the varint path of the protobuf decoder. Each beat carries up to BYTES message bytes. For each beat the block produces a per-byte varint-terminator mask, which the downstream population-count adder tree reduces to a varints-completed-per-beat count. It also tracks the length of a varint that spans beats and flags overlong and truncated varints.

## Interface
- BYTES, 8, bytes per beat; also the width of the terminator mask fed to the adder tree.
- MAX_LEN, 10, maximum legal varint length in bytes.
- CW, $clog2(BYTES+1), width of the byte-count field.
- LW, $clog2(MAX_LEN+1), width of the open-length field.
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  8*BYTES  bytes; byte i is bits [8i+7:8i], and byte 0 comes first in stream order.
- in_count  in  CW  number of valid bytes, 0..BYTES, packed from byte 0; 0 is legal only with in_last.
- in_last  in  1  final beat of the message.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_end_mask  out  BYTES  bit i set when byte i terminates a varint; this is the adder-tree input.
- out_keep  out  BYTES  thermometer mask of valid bytes.
- out_open_len  out  LW  bytes of the unterminated varint at the end of the beat.
- out_last  out  1  final output beat of the message.
- err_overlong  out  1  qualified by out_valid; a varint exceeded MAX_LEN bytes.
- err_truncated  out  1  qualified by out_valid; the message ended inside a varint.

## Operation
- The state machine has two states, SCAN and DRAIN.
- Per-byte rule, for valid byte i: `end[i] = ~in_data[8i+7]`.
- Running length:
  - `len` starts each beat at `open_len_q`.
  - Each valid byte increments `len`.
  - A terminator resets `len` to 0 after that byte.
- SCAN beat, no error:
  - out_end_mask = end & keep.
  - out_open_len = final `len`.
  - out_last = in_last.
- Overlong: the byte whose increment makes `len` = MAX_LEN+1 is the offending byte.
  - The beat is emitted with out_end_mask limited to bytes before the offending byte.
  - out_keep covers all valid bytes.
  - err_overlong=1, out_open_len=0, out_last=1 (forced).
  - If in_last=0, go to DRAIN. If in_last=1, stay in SCAN.
- DRAIN:
  - Keep in_ready=1 and produce no output.
  - Discard beats up to and including the in_last beat, then return to SCAN.
- Truncated: in SCAN, an in_last beat whose final `len` ≠ 0 is emitted with err_truncated=1.
  - If the same beat is overlong, err_overlong takes priority and err_truncated=0.
- open_len_q:
  - Updates to final `len` on every accepted SCAN beat.
  - Forced to 0 after any in_last beat and after an overlong beat.
- in_count=0 with in_last:
  - Emits a beat with an empty mask and keep.
  - Carries err_truncated if open_len_q ≠ 0.

## Timing
- Outputs come from one registered stage; latency is 1 cycle from input acceptance to out_valid.
- in_ready = DRAIN | ~out_valid | out_ready. This gives full throughput of one beat per cycle with no bubble under continuous out_ready.
- While out_valid & ~out_ready, every out_* and err_* signal stays stable.
- In DRAIN, the accepted beats never assert out_valid. A buffered output beat is still held until out_ready.
- Reset values:
  - out_valid=0, in_ready=1.
  - out_end_mask=0, out_keep=0, out_open_len=0, out_last=0, err_overlong=0, err_truncated=0.
  - State = SCAN, open_len_q=0.
- Reset mid-message discards the buffered beat and any partial varint. No error is reported.

## Structure
- Shared package `pb_varint_pkg` holds:
  - VARINT_MAX_BYTES=10.
  - The scanner state enum `scan_state_e` {SCAN, DRAIN}.
  - A thermometer helper function, count→keep.
- Sub-module `varint_len_scan` is combinational. It takes data, count and start length, and returns the end mask, final length, an overlong flag and the offending byte index. The top level holds the state machine, open_len_q and the output register.

## Test plan
- Reset: assert rst mid-beat. Expect:
  - all outputs 0 and in_ready=1 immediately;
  - after release, the next beat decodes from open_len 0.
- Single beat: bytes 96 01 05 80, count=4, last=0. Expect:
  - end_mask=0b0110, keep=0b00001111, open_len=1;
  - output one cycle after acceptance.
- Spanning varint: beat A is eight bytes of 0x80. Beat B is 80 01, count=2, last=1. Expect:
  - A: end_mask=0, open_len=8;
  - B: end_mask=0b10, open_len=0, last=1, no errors.
- Overlong: beat A is eight bytes of 0x80, last=0. Beat B is 80 80 80 01, count=4, last=0. Expect:
  - B: err_overlong=1, out_last=1, end_mask=0, keep=0b1111;
  - two following beats, ending with last, produce no output;
  - the next message byte 07 gives end_mask=0b1.
- Truncated: bytes 80 80 80, count=3, last=1. Expect:
  - err_truncated=1, open_len=3, out_last=1;
  - the next beat starts at open_len 0.
- Backpressure: hold out_ready=0 for 3 cycles while in_valid streams 4 beats. Expect:
  - the output is stable and in_ready=0;
  - once out_ready returns, all 4 beats arrive in order with no loss or duplication.

Source files
------------

// File: rtl/pb_varint_pkg.sv
// pb_varint_pkg: shared constants, scanner state and keep-mask helper for the varint path.
package pb_varint_pkg;
  localparam int VARINT_MAX_BYTES = 10;
  typedef enum logic {SCAN = 1'b0, DRAIN = 1'b1} scan_state_e;
  function automatic logic [63:0] therm(input int n);
    return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
  endfunction
endpackage

// File: rtl/varint_len_scan.sv
// varint_len_scan: per-beat terminator mask and running varint length, purely combinational.
module varint_len_scan
  import pb_varint_pkg::*;
#(
  parameter int BYTES   = 8,
  parameter int MAX_LEN = VARINT_MAX_BYTES,
  parameter int CW      = $clog2(BYTES + 1),
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic [8*BYTES-1:0] data,
  input  logic [CW-1:0]      count,
  input  logic [LW-1:0]      start_len,
  output logic [BYTES-1:0]   end_mask,
  output logic [LW-1:0]      final_len,
  output logic               overlong,
  output logic [CW-1:0]      bad_idx
);
  logic [LW:0] len;
  logic [BYTES-1:0] keep;
  assign keep = BYTES'(therm(int'(count)));
  always_comb begin
    end_mask = '0;
    for (int i = 0; i < BYTES; i++) end_mask[i] = ~data[8*i+7] & keep[i];
  end
  // One extra length bit so the overflowing byte is still detectable after the increment.
  always_comb begin
    len = {1'b0, start_len};
    overlong = 1'b0;
    bad_idx = '0;
    for (int i = 0; i < BYTES; i++)
      if (keep[i] && !overlong) begin
        len = len + (LW+1)'(1);
        if (len > (LW+1)'(MAX_LEN)) begin
          overlong = 1'b1;
          bad_idx = CW'(i);
        end else if (!data[8*i+7]) len = '0;
      end
    final_len = len[LW-1:0];
  end
endmodule

// File: rtl/varint_boundary_scanner.sv
// varint_boundary_scanner: registered per-beat varint terminator mask with span tracking and overlong/truncated flags.
module varint_boundary_scanner
  import pb_varint_pkg::*;
#(
  parameter int BYTES   = 8,
  parameter int MAX_LEN = VARINT_MAX_BYTES,
  parameter int CW      = $clog2(BYTES + 1),
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*BYTES-1:0] in_data,
  input  logic [CW-1:0]      in_count,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BYTES-1:0]   out_end_mask,
  output logic [BYTES-1:0]   out_keep,
  output logic [LW-1:0]      out_open_len,
  output logic               out_last,
  output logic               err_overlong,
  output logic               err_truncated
);
  scan_state_e state_q;
  logic [LW-1:0] open_len_q, fin;
  logic [BYTES-1:0] keep, raw_mask, lim;
  logic [CW-1:0] bad;
  logic ov, acc;
  varint_len_scan #(.BYTES(BYTES), .MAX_LEN(MAX_LEN), .CW(CW), .LW(LW)) u_scan (
    .data(in_data),
    .count(in_count),
    .start_len(open_len_q),
    .end_mask(raw_mask),
    .final_len(fin),
    .overlong(ov),
    .bad_idx(bad)
  );
  assign keep = BYTES'(therm(int'(in_count)));
  assign lim = ov ? BYTES'(therm(int'(bad))) : '1;
  assign in_ready = (state_q == DRAIN) | ~out_valid | out_ready;
  assign acc = in_valid & in_ready;
  // Drain beats never touch the output register, so a held beat survives them.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SCAN;
      open_len_q <= '0;
      out_valid <= 1'b0;
      out_end_mask <= '0;
      out_keep <= '0;
      out_open_len <= '0;
      out_last <= 1'b0;
      err_overlong <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (acc && state_q == DRAIN) state_q <= in_last ? SCAN : DRAIN;
      else if (acc) begin
        out_valid <= 1'b1;
        out_end_mask <= raw_mask & lim;
        out_keep <= keep;
        out_open_len <= ov ? '0 : fin;
        out_last <= in_last | ov;
        err_overlong <= ov;
        err_truncated <= ~ov & in_last & (fin != '0);
        state_q <= (ov && !in_last) ? DRAIN : SCAN;
        open_len_q <= (ov || in_last) ? '0 : fin;
      end
    end
endmodule

// File: tb/tb_varint_boundary_scanner.sv
// tb_varint_boundary_scanner: directed and random beats checked against a byte-level stream model.
module tb_varint_boundary_scanner;
  localparam int BYTES = 8, MAX_LEN = 10, CW = 4, LW = 4;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [63:0] in_data = '0;
  logic [CW-1:0] in_count = '0;
  logic in_ready, out_valid, out_last, err_overlong, err_truncated;
  logic [BYTES-1:0] out_end_mask, out_keep;
  logic [LW-1:0] out_open_len;
  typedef struct packed {
    logic [BYTES-1:0] mask;
    logic [BYTES-1:0] keep;
    logic [LW-1:0] olen;
    logic last;
    logic eo;
    logic et;
  } beat_t;
  beat_t eq[$];
  beat_t hs;
  bit held = 0, done = 0, m_drain = 0;
  int m_open = 0, n_chk = 0, n_pass = 0;

  varint_boundary_scanner dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_count(in_count), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_end_mask(out_end_mask), .out_keep(out_keep), .out_open_len(out_open_len),
    .out_last(out_last), .err_overlong(err_overlong), .err_truncated(err_truncated)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  // Stream model: walk the message bytes, counting bytes since the last terminator.
  task automatic model(input logic [63:0] d, input int cnt, input bit last);
    beat_t e;
    int len;
    bit ov;
    logic [7:0] b;
    if (m_drain) begin
      if (last) m_drain = 0;
      return;
    end
    e = '0;
    ov = 0;
    len = m_open;
    for (int i = 0; i < cnt; i++) begin
      b = d[8*i+:8];
      len++;
      if (len > MAX_LEN) begin
        ov = 1;
        break;
      end
      if (!b[7]) begin
        e.mask[i] = 1'b1;
        len = 0;
      end
    end
    e.keep = BYTES'((1 << cnt) - 1);
    if (ov) begin
      e.eo = 1;
      e.last = 1;
      m_open = 0;
      m_drain = !last;
    end else begin
      e.olen = LW'(len);
      e.last = last;
      e.et = last && len != 0;
      m_open = last ? 0 : len;
    end
    eq.push_back(e);
  endtask

  task automatic send(input logic [63:0] d, input int cnt, input bit last);
    bit ok = 0;
    in_valid = 1;
    in_data = d;
    in_count = CW'(cnt);
    in_last = last;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      if (ok) model(d, cnt, last);
      #1;
    end
    if (!ok) chk("accept_timeout", 64'(in_ready), 1);
    in_valid = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 0);
    chk({tag, "_ready"}, 64'(in_ready), 1);
    chk({tag, "_outs"}, 64'({out_end_mask, out_keep, out_open_len, out_last, err_overlong, err_truncated}), 0);
  endtask

  always @(negedge clk) begin
    beat_t e, cur;
    cur = {out_end_mask, out_keep, out_open_len, out_last, err_overlong, err_truncated};
    if (rst) held = 0;
    else begin
      if (out_valid && out_ready) begin
        if (eq.size() == 0) chk("unexpected_beat", 64'(out_valid), 0);
        else begin
          e = eq.pop_front();
          chk("sb_mask", 64'(cur.mask), 64'(e.mask));
          chk("sb_keep", 64'(cur.keep), 64'(e.keep));
          chk("sb_olen", 64'(cur.olen), 64'(e.olen));
          chk("sb_flags", 64'({cur.last, cur.eo, cur.et}), 64'({e.last, e.eo, e.et}));
        end
      end
      if (out_valid && !out_ready) begin
        if (held) chk("bp_stable", 64'(cur), 64'(hs));
        hs = cur;
        held = 1;
      end else held = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] d;
    int c;
    bit l;
    @(posedge clk);
    #1;
    chk_reset("rst_init");
    rst = 0;
    // Asynchronous reset with a held output beat and an open varint.
    out_ready = 0;
    send(64'h8080808080808080, 8, 0);
    chk("pre_rst_valid", 64'(out_valid), 1);
    in_valid = 1;
    in_data = 64'h0180;
    in_count = 2;
    rst = 1;
    #1;
    chk_reset("rst_mid");
    eq.delete();
    m_open = 0;
    m_drain = 0;
    @(posedge clk);
    #1;
    rst = 0;
    in_valid = 0;
    out_ready = 1;
    send(64'h80, 1, 0);
    chk("post_rst_olen", 64'(out_open_len), 1);
    send(64'h00, 1, 1);
    // Single beat.
    send(64'h0000_0000_8005_0196, 4, 0);
    chk("single_latency", 64'(out_valid), 1);
    chk("single_mask", 64'(out_end_mask), 64'b0110);
    chk("single_keep", 64'(out_keep), 64'h0f);
    chk("single_olen", 64'(out_open_len), 1);
    send(64'h00, 1, 1);
    // Varint spanning two beats.
    send(64'h8080808080808080, 8, 0);
    chk("span_a_mask", 64'(out_end_mask), 0);
    chk("span_a_olen", 64'(out_open_len), 8);
    send(64'h0180, 2, 1);
    chk("span_b_mask", 64'(out_end_mask), 64'b10);
    chk("span_b_flags", 64'({out_open_len, out_last, err_overlong, err_truncated}), 64'b0000_100);
    // Overlong, then drain to the end of the message.
    send(64'h8080808080808080, 8, 0);
    send(64'h0180_8080, 4, 0);
    chk("ovl_flags", 64'({out_last, err_overlong, err_truncated}), 64'b110);
    chk("ovl_mask", 64'(out_end_mask), 0);
    chk("ovl_keep", 64'(out_keep), 64'h0f);
    send(64'h1122334455667788, 8, 0);
    chk("drain1_none", 64'(out_valid), 0);
    send(64'h0000000000808080, 3, 1);
    chk("drain2_none", 64'(out_valid), 0);
    send(64'h07, 1, 0);
    chk("after_drain_mask", 64'(out_end_mask), 1);
    chk("after_drain_eo", 64'(err_overlong), 0);
    // Truncated message and the empty last beat.
    send(64'h808080, 3, 1);
    chk("trunc_flags", 64'({out_open_len, out_last, err_overlong, err_truncated}), 64'b0011_101);
    send(64'h05, 1, 0);
    chk("trunc_next_olen", 64'(out_open_len), 0);
    chk("trunc_next_mask", 64'(out_end_mask), 1);
    send(64'h80, 1, 0);
    send(64'h0, 0, 1);
    chk("empty_last", 64'({out_end_mask, out_keep, err_truncated, out_last}), 64'b11);
    send(64'h0, 0, 1);
    chk("empty_clean", 64'(err_truncated), 0);
    // Backpressure while four beats stream.
    fork
      for (int k = 0; k < 4; k++) begin
        d = {$urandom, $urandom};
        d[7] = 1'b0;
        send(d, $urandom_range(1, 8), 0);
      end
      begin
        out_ready = 0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk);
          #1;
          chk("bp_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_all_out", 64'(eq.size()), 0);
    // Random traffic under random backpressure.
    done = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          for (int i = 0; i < BYTES; i++) begin
            d[8*i+:8] = 8'($urandom);
            d[8*i+7] = ($urandom_range(0, 2) != 0);
          end
          l = ($urandom_range(0, 7) == 0);
          c = l ? $urandom_range(0, 8) : $urandom_range(1, 8);
          send(d, c, l);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("final_empty", 64'(eq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
